// File: rtl/seq_mult_param.sv
// seq_mult_param: parametrised sequential shift-add multiplier with control
// sequencer, signed (two's-complement) mode, abort and status outputs.
//
// Handshake: start is a level request. An operation begins on a rising clk
// edge where the sequencer is in IDLE and start=1; operands and signed_mode
// are captured on that same edge. The result is presented in READY. With
// HOLD_READY=1, ready stays high until start drops. With HOLD_READY=0,
// ready is a single-cycle pulse. A start still high in IDLE launches the
// next operation. abort in LOAD/ITER returns to IDLE without touching
// product.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        level request (sampled in IDLE, and in READY when HOLD_READY=1)
//   signed_mode  1: operands/product are two's complement, 0: unsigned
//   multiplicand operand A (WIDTH bits)
//   multiplier   operand B (WIDTH bits)
//   abort        cancel an operation in LOAD/ITER
//   one_shot     high in LOAD
//   first        high in the first ITER cycle only
//   busy         high in LOAD and ITER
//   ready        high in READY
//   step_count   iteration index 1..WIDTH in ITER, else 0
//   product      2*WIDTH-bit result register
//   dbg_state    current sequencer state encoding
module seq_mult_param #(
  parameter int WIDTH      = 8,
  parameter bit HOLD_READY = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [WIDTH-1:0]           multiplicand,
  input  logic [WIDTH-1:0]           multiplier,
  input  logic                       abort,
  output logic                       one_shot,
  output logic                       first,
  output logic                       busy,
  output logic                       ready,
  output logic [$clog2(WIDTH+1)-1:0] step_count,
  output logic [2*WIDTH-1:0]         product,
  output logic [1:0]                 dbg_state
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ITER  = 2'd2,
    S_READY = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   mcand_r;   // captured operand, then its magnitude
  logic [WIDTH-1:0]   mplier_r;  // captured operand, then magnitude shifted out LSB-first
  logic               smode_r;
  logic               sign_r;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_next;
  logic [2*WIDTH-1:0] res;
  logic               last_step;

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign last_step = (cnt == LAST_STEP);

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  state_next = abort ? S_IDLE : S_ITER;
      S_ITER: begin
        // abort has priority over completion so product is never updated
        if (abort)          state_next = S_IDLE;
        else if (last_step) state_next = S_READY;
      end
      S_READY: if (!HOLD_READY || !start) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state and iteration counter
  assign one_shot   = (state == S_LOAD);
  assign first      = (state == S_ITER) && (cnt == CW'(1));
  assign busy       = (state == S_LOAD) || (state == S_ITER);
  assign ready      = (state == S_READY);
  assign step_count = (state == S_ITER) ? cnt : '0;
  assign dbg_state  = state;

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  // One shift-add step: add the multiplicand magnitude into the upper
  // WIDTH+1 bits of the accumulator, then shift the whole thing right.
  always_comb begin
    addend   = mplier_r[0] ? mcand_r : {WIDTH{1'b0}};
    sum      = acc[2*WIDTH:WIDTH] + {1'b0, addend};
    acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    res      = acc_next[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      smode_r  <= 1'b0;
      sign_r   <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      product  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mcand_r  <= multiplicand;
            mplier_r <= multiplier;
            smode_r  <= signed_mode;
          end
        end
        S_LOAD: begin
          // The most-negative value negates to itself, which read unsigned
          // is exactly its magnitude 2^(WIDTH-1).
          mcand_r  <= (smode_r && mcand_r[WIDTH-1])  ? -mcand_r  : mcand_r;
          mplier_r <= (smode_r && mplier_r[WIDTH-1]) ? -mplier_r : mplier_r;
          sign_r   <= smode_r & (mcand_r[WIDTH-1] ^ mplier_r[WIDTH-1]);
          acc      <= '0;
          cnt      <= CW'(1);
        end
        S_ITER: begin
          acc      <= acc_next;
          mplier_r <= mplier_r >> 1;
          cnt      <= cnt + CW'(1);
          if (last_step && !abort) begin
            product <= sign_r ? -res : res;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
module tb_seq_mult_param;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance a: WIDTH=8, HOLD_READY=1
  logic        start_a = 0, smode_a = 0, abort_a = 0;
  logic [7:0]  mcand_a = 0, mplier_a = 0;
  logic        one_shot_a, first_a, busy_a, ready_a;
  logic [3:0]  step_a;
  logic [15:0] product_a;
  logic [1:0]  dbg_a;

  // Instance b: WIDTH=8, HOLD_READY=0
  logic        start_b = 0, smode_b = 0, abort_b = 0;
  logic [7:0]  mcand_b = 0, mplier_b = 0;
  logic        one_shot_b, first_b, busy_b, ready_b;
  logic [3:0]  step_b;
  logic [15:0] product_b;
  logic [1:0]  dbg_b;

  // Instance c: WIDTH=16, HOLD_READY=1
  logic        start_c = 0, smode_c = 0, abort_c = 0;
  logic [15:0] mcand_c = 0, mplier_c = 0;
  logic        one_shot_c, first_c, busy_c, ready_c;
  logic [4:0]  step_c;
  logic [31:0] product_c;
  logic [1:0]  dbg_c;

  seq_mult_param #(.WIDTH(8), .HOLD_READY(1'b1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .signed_mode(smode_a),
    .multiplicand(mcand_a), .multiplier(mplier_a), .abort(abort_a),
    .one_shot(one_shot_a), .first(first_a), .busy(busy_a), .ready(ready_a),
    .step_count(step_a), .product(product_a), .dbg_state(dbg_a)
  );

  seq_mult_param #(.WIDTH(8), .HOLD_READY(1'b0)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .signed_mode(smode_b),
    .multiplicand(mcand_b), .multiplier(mplier_b), .abort(abort_b),
    .one_shot(one_shot_b), .first(first_b), .busy(busy_b), .ready(ready_b),
    .step_count(step_b), .product(product_b), .dbg_state(dbg_b)
  );

  seq_mult_param #(.WIDTH(16), .HOLD_READY(1'b1)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .signed_mode(smode_c),
    .multiplicand(mcand_c), .multiplier(mplier_c), .abort(abort_c),
    .one_shot(one_shot_c), .first(first_c), .busy(busy_c), .ready(ready_c),
    .step_count(step_c), .product(product_c), .dbg_state(dbg_c)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  logic [31:0] exp_c_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: interpret operands per mode, multiply as integers, keep 2w bits
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input bit s, input int w);
    longint sa, sb, p;
    logic [63:0] pm;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p  = sa * sb;
    pm = p;
    pm = pm & ((64'd1 << (2*w)) - 64'd1);
    return pm[31:0];
  endfunction

  // Monitors: on each rising ready, pop the oldest expectation and compare
  logic ready_a_q = 0, ready_b_q = 0, ready_c_q = 0;

  always @(negedge clk) begin
    if (ready_a && !ready_a_q) begin
      if (exp_a_q.size() == 0) check("a_unexpected_ready", 32'd1, 32'd0);
      else                     check("a_product", {16'h0, product_a}, {16'h0, exp_a_q.pop_front()});
    end
    ready_a_q <= ready_a;
  end

  always @(negedge clk) begin
    if (ready_b && !ready_b_q) begin
      if (exp_b_q.size() == 0) check("b_unexpected_ready", 32'd1, 32'd0);
      else                     check("b_product", {16'h0, product_b}, {16'h0, exp_b_q.pop_front()});
    end
    ready_b_q <= ready_b;
  end

  always @(negedge clk) begin
    if (ready_c && !ready_c_q) begin
      if (exp_c_q.size() == 0) check("c_unexpected_ready", 32'd1, 32'd0);
      else                     check("c_product", product_c, exp_c_q.pop_front());
    end
    ready_c_q <= ready_c;
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  // Full operation on instance a. abort_step=0: no abort; otherwise abort is
  // raised while step_count equals abort_step.
  task automatic op_a(input logic [7:0] a, input logic [7:0] b, input bit s,
                      input int abort_step, input int hold_cycles);
    logic [15:0] prev;
    logic [31:0] r;
    @(negedge clk);
    prev     = product_a;
    mcand_a  = a;
    mplier_a = b;
    smode_a  = s;
    start_a  = 1'b1;
    if (abort_step == 0) begin
      r = ref_mul({8'h0, a}, {8'h0, b}, s, 8);
      exp_a_q.push_back(r[15:0]);
    end
    @(negedge clk);  // cycle 1: LOAD
    check("a_one_shot", {31'h0, one_shot_a}, 32'd1);
    check("a_busy_load", {31'h0, busy_a}, 32'd1);
    // operands are don't-care after the capture edge
    mcand_a  = 8'($urandom);
    mplier_a = 8'($urandom);
    smode_a  = 1'($urandom);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);  // cycle i+1: ITER step i
      check("a_step_count", {28'h0, step_a}, i);
      check("a_first", {31'h0, first_a}, (i == 1) ? 32'd1 : 32'd0);
      if (i == abort_step) begin
        abort_a = 1'b1;
        start_a = 1'b0;
        @(negedge clk);
        abort_a = 1'b0;
        check("a_abort_busy", {31'h0, busy_a}, 32'd0);
        check("a_abort_ready", {31'h0, ready_a}, 32'd0);
        repeat (3) @(negedge clk);
        check("a_abort_product", {16'h0, product_a}, {16'h0, prev});
        check("a_abort_no_ready", {31'h0, ready_a}, 32'd0);
        return;
      end
    end
    @(negedge clk);  // cycle 10: READY
    check("a_ready_latency", {31'h0, ready_a}, 32'd1);
    check("a_busy_ready", {31'h0, busy_a}, 32'd0);
    repeat (hold_cycles) begin
      @(negedge clk);
      check("a_ready_hold", {31'h0, ready_a}, 32'd1);
    end
    start_a = 1'b0;
    @(negedge clk);
    check("a_ready_release", {31'h0, ready_a}, 32'd0);
    check("a_idle_busy", {31'h0, busy_a}, 32'd0);
  endtask

  task automatic op_c(input logic [15:0] a, input logic [15:0] b, input bit s);
    @(negedge clk);
    mcand_c  = a;
    mplier_c = b;
    smode_c  = s;
    start_c  = 1'b1;
    exp_c_q.push_back(ref_mul(a, b, s, 16));
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      check("c_ready_timing", {31'h0, ready_c}, (cyc == 18) ? 32'd1 : 32'd0);
    end
    start_c = 1'b0;
    @(negedge clk);
    check("c_ready_release", {31'h0, ready_c}, 32'd0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin
    logic [7:0] ra, rb;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_product_a", {16'h0, product_a}, 32'd0);
    check("rst_ready_a", {31'h0, ready_a}, 32'd0);
    check("rst_busy_a", {31'h0, busy_a}, 32'd0);
    check("rst_step_a", {28'h0, step_a}, 32'd0);
    check("rst_product_c", product_c, 32'd0);
    reset = 1'b1;

    // Directed cases
    op_a(8'hFF, 8'hFF, 1'b0, 0, 2);
    op_a(8'h80, 8'h80, 1'b1, 0, 0);
    op_a(8'hFD, 8'h05, 1'b1, 0, 1);
    op_a(8'h7F, 8'hFF, 1'b1, 0, 0);
    op_a(8'h00, 8'hF9, 1'b1, 0, 0);
    op_a(8'h80, 8'h80, 1'b0, 0, 0);

    // Abort mid-run and on the final iteration
    op_a(8'd6, 8'd7, 1'b0, 0, 0);
    op_a(8'd200, 8'd3, 1'b0, 4, 0);
    op_a(8'd200, 8'd3, 1'b0, 8, 0);
    check("a_product_after_aborts", {16'h0, product_a}, 32'h002A);

    // Async reset during ITER step 5
    @(negedge clk);
    mcand_a  = 8'd200;
    mplier_a = 8'd3;
    smode_a  = 1'b0;
    start_a  = 1'b1;
    repeat (6) @(negedge clk);
    check("a_pre_reset_step", {28'h0, step_a}, 32'd5);
    #2 reset = 1'b0;
    #1;
    check("a_reset_product", {16'h0, product_a}, 32'd0);
    check("a_reset_ctrl", {28'h0, one_shot_a, first_a, busy_a, ready_a}, 32'd0);
    check("a_reset_step", {28'h0, step_a}, 32'd0);
    start_a = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    op_a(8'd9, 8'd9, 1'b0, 0, 0);

    // Randomised operations
    for (int n = 0; n < 30; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op_a(ra, rb, 1'($urandom), 0, $urandom_range(0, 2));
    end

    // Single-cycle ready pulse with automatic restart
    @(negedge clk);
    mcand_b  = 8'd3;
    mplier_b = 8'd4;
    smode_b  = 1'b0;
    start_b  = 1'b1;
    exp_b_q.push_back(16'h000C);
    exp_b_q.push_back(16'h000C);
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      check("b_ready_pulse", {31'h0, ready_b}, (cyc == 10 || cyc == 21) ? 32'd1 : 32'd0);
      check("b_one_shot", {31'h0, one_shot_b}, (cyc == 1 || cyc == 12) ? 32'd1 : 32'd0);
      if (cyc == 21) start_b = 1'b0;
    end
    check("b_idle_busy", {31'h0, busy_b}, 32'd0);

    // WIDTH=16
    op_c(16'hFFFF, 16'h0001, 1'b0);
    op_c(16'h8000, 16'h7FFF, 1'b1);
    for (int n = 0; n < 4; n++) begin
      op_c(16'($urandom), 16'($urandom), 1'($urandom));
    end

    repeat (2) @(negedge clk);
    check("a_queue_drained", exp_a_q.size(), 32'd0);
    check("b_queue_drained", exp_b_q.size(), 32'd0);
    check("c_queue_drained", exp_c_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
